// File: rtl/icache_miss_ctrl_pkg.sv
// Shared types and helpers for the instruction-cache miss/refill controller.
package icache_miss_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        FILL   = 2'd2,
        COMMIT = 2'd3
    } icache_state_t;

    localparam int WORDS_PER_LINE_DEF = 4;

    // Byte-offset width of a cache line: log2(words * bytes per word).
    function automatic int line_offs(input int words_per_line, input int data_w);
        return $clog2(words_per_line * data_w / 8);
    endfunction

endpackage

// File: rtl/icache_miss_ctrl.sv
// Fetch-stage I-cache miss controller: stalls fetch on a miss, requests one line,
// writes the returning beats into the data array and commits the tag.
module icache_miss_ctrl
    import icache_miss_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [ADDR_W-1:0]                 pc_f_i,
    input  logic                              lookup_hit_i,
    output logic                              instr_miss_f_o,
    output logic                              instr_cache_rep_en_o,
    output logic                              mem_req_valid_o,
    input  logic                              mem_req_ready_i,
    output logic [ADDR_W-1:0]                 mem_req_addr_o,
    input  logic                              mem_rsp_valid_i,
    input  logic [DATA_W-1:0]                 mem_rsp_data_i,
    output logic                              fill_we_o,
    output logic [ADDR_W-1:0]                 fill_addr_o,
    output logic [$clog2(WORDS_PER_LINE)-1:0] fill_word_idx_o,
    output logic [DATA_W-1:0]                 fill_data_o
);

    localparam int OFFS  = line_offs(WORDS_PER_LINE, DATA_W);
    localparam int CNT_W = $clog2(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_LINE - 1);

    icache_state_t     state_r;
    icache_state_t     state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] line_addr_s;
    logic              req_fire_s;
    logic              beat_s;
    logic              unused_offs_s;

    assign line_addr_s   = {pc_f_i[ADDR_W-1:OFFS], {OFFS{1'b0}}};
    assign unused_offs_s = ^pc_f_i[OFFS-1:0];
    assign req_fire_s    = (state_r == REQ) && mem_req_ready_i;
    assign beat_s        = (state_r == FILL) && mem_rsp_valid_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; once a miss is taken the line always runs to commit.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!lookup_hit_i) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (mem_req_ready_i) begin
                    state_next_s = FILL;
                end else begin
                    state_next_s = REQ;
                end
            end
            FILL: begin
                if (mem_rsp_valid_i && (cnt_r == LAST_IDX)) begin
                    state_next_s = COMMIT;
                end else begin
                    state_next_s = FILL;
                end
            end
            COMMIT:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Line address captured on the miss and held for the whole refill.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_r <= {ADDR_W{1'b0}};
        end else if ((state_r == IDLE) && !lookup_hit_i) begin
            addr_r <= line_addr_s;
        end else begin
            addr_r <= addr_r;
        end
    end

    // Beat counter: cleared on request handshake, wraps to zero on the last beat.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (req_fire_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (beat_s) begin
            if (cnt_r == LAST_IDX) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Output decode; the stall in IDLE follows the same-cycle lookup and is masked in reset.
    always_comb begin
        instr_miss_f_o       = 1'b0;
        instr_cache_rep_en_o = 1'b0;
        mem_req_valid_o      = 1'b0;
        mem_req_addr_o       = {ADDR_W{1'b0}};
        fill_we_o            = 1'b0;
        fill_addr_o          = addr_r;
        fill_word_idx_o      = cnt_r;
        fill_data_o          = {DATA_W{1'b0}};
        case (state_r)
            IDLE: begin
                instr_miss_f_o = rst_n_i & ~lookup_hit_i;
                fill_addr_o    = {ADDR_W{1'b0}};
            end
            REQ: begin
                instr_miss_f_o  = 1'b1;
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = addr_r;
            end
            FILL: begin
                instr_miss_f_o = 1'b1;
                fill_we_o      = mem_rsp_valid_i;
                if (mem_rsp_valid_i) begin
                    fill_data_o = mem_rsp_data_i;
                end else begin
                    fill_data_o = {DATA_W{1'b0}};
                end
            end
            COMMIT: begin
                instr_miss_f_o       = 1'b1;
                instr_cache_rep_en_o = 1'b1;
            end
            default: begin
                instr_miss_f_o = 1'b0;
                fill_addr_o    = {ADDR_W{1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// Self-checking bench for icache_miss_ctrl: transaction-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_icache_miss_ctrl;

    localparam int WPL        = 4;
    localparam int LINE_BYTES = 16;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] pc_f_i;
    logic        lookup_hit_i;
    logic        instr_miss_f_o;
    logic        instr_cache_rep_en_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        fill_we_o;
    logic [31:0] fill_addr_o;
    logic [1:0]  fill_word_idx_o;
    logic [31:0] fill_data_o;

    icache_miss_ctrl #(.ADDR_W(32), .DATA_W(32), .WORDS_PER_LINE(WPL)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .pc_f_i(pc_f_i), .lookup_hit_i(lookup_hit_i),
        .instr_miss_f_o(instr_miss_f_o), .instr_cache_rep_en_o(instr_cache_rep_en_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_data_i(mem_rsp_data_i), .fill_we_o(fill_we_o), .fill_addr_o(fill_addr_o),
        .fill_word_idx_o(fill_word_idx_o), .fill_data_o(fill_data_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding miss, described by its progress.
    bit          m_active;
    logic [31:0] m_line;
    bit          m_req_done;
    int          m_beats;

    always @(posedge clk_i) begin
        if (!rst_n_i) begin
            m_active = 1'b0; m_req_done = 1'b0; m_beats = 0; m_line = 32'h0;
        end else if (!m_active) begin
            if (!lookup_hit_i) begin
                m_active = 1'b1; m_req_done = 1'b0; m_beats = 0;
                m_line = pc_f_i - (pc_f_i % LINE_BYTES);
            end
        end else if (!m_req_done) begin
            if (mem_req_ready_i) m_req_done = 1'b1;
        end else if (m_beats < WPL) begin
            if (mem_rsp_valid_i) m_beats++;
        end else begin
            m_active = 1'b0;
        end
    end

    // Observation logs used by the directed checks.
    int          miss_cyc, req_cyc, rep_cnt;
    logic [31:0] req_addr_first;
    bit          req_addr_moved;
    int          wr_idx_q[$];
    logic [31:0] wr_data_q[$];

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        logic        e_miss, e_req, e_we, e_rep;
        logic [31:0] e_faddr;
        e_miss = 1'b0; e_req = 1'b0; e_we = 1'b0; e_rep = 1'b0; e_faddr = 32'h0;
        if (rst_n_i) begin
            if (m_active) e_faddr = m_line;
            if (!m_active)               e_miss = ~lookup_hit_i;
            else if (!m_req_done)        begin e_miss = 1'b1; e_req = 1'b1; end
            else if (m_beats < WPL)      begin e_miss = 1'b1; e_we = mem_rsp_valid_i; end
            else                         begin e_miss = 1'b1; e_rep = 1'b1; end
        end
        chk("miss", instr_miss_f_o, e_miss);
        chk("req_valid", mem_req_valid_o, e_req);
        chk("fill_we", fill_we_o, e_we);
        chk("rep_en", instr_cache_rep_en_o, e_rep);
        chk("fill_addr", fill_addr_o, e_faddr);
        if (e_req) chk("req_addr", mem_req_addr_o, m_line);
        if (e_we) begin
            chk("fill_idx", fill_word_idx_o, m_beats);
            chk("fill_data", fill_data_o, mem_rsp_data_i);
        end
        if (rst_n_i && instr_miss_f_o) miss_cyc++;
        if (instr_cache_rep_en_o) rep_cnt++;
        if (mem_req_valid_o) begin
            if (req_cyc == 0) req_addr_first = mem_req_addr_o;
            else if (mem_req_addr_o !== req_addr_first) req_addr_moved = 1'b1;
            req_cyc++;
        end
        if (fill_we_o) begin
            wr_idx_q.push_back(int'(fill_word_idx_o));
            wr_data_q.push_back(fill_data_o);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_logs();
        miss_cyc = 0; req_cyc = 0; rep_cnt = 0;
        req_addr_first = 32'h0; req_addr_moved = 1'b0;
        wr_idx_q.delete();
        wr_data_q.delete();
    endtask

    task automatic run_miss(input logic [31:0] pc, input int rdy_wait,
                            input logic [15:0] vpat, input int vlen, input logic [31:0] dbase);
        int k;
        k = 0;
        pc_f_i = pc; lookup_hit_i = 1'b0; mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
        tick();
        repeat (rdy_wait) tick();
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        for (int i = 0; i < vlen; i++) begin
            pc_f_i = pc + 32'h100;
            mem_rsp_valid_i = vpat[i];
            mem_rsp_data_i  = vpat[i] ? dbase + 32'(k) : 32'hDEAD_BEEF;
            if (vpat[i]) k++;
            tick();
        end
        mem_rsp_valid_i = 1'b0; pc_f_i = pc; lookup_hit_i = 1'b1;
        tick();
        tick();
    endtask

    task automatic check_writes(input int n, input logic [31:0] dbase);
        chk("wr_count", wr_idx_q.size(), n);
        for (int i = 0; i < n && i < wr_idx_q.size(); i++) begin
            chk("wr_idx", wr_idx_q[i], i);
            chk("wr_data", wr_data_q[i], dbase + 32'(i));
        end
    endtask

    initial begin
        rst_n_i = 1'b0; pc_f_i = 32'h0000_1234; lookup_hit_i = 1'b0;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = 32'h0;
        clear_logs();

        // 1: reset with a missing lookup keeps everything low
        tick(); tick();
        chk("rst_miss", instr_miss_f_o, 1'b0);
        chk("rst_req", mem_req_valid_o, 1'b0);
        chk("rst_fill_addr", fill_addr_o, 32'h0);
        clear_logs();
        rst_n_i = 1'b1;
        #1;
        chk("release_miss", instr_miss_f_o, 1'b1);

        // 2: back-to-back refill
        run_miss(32'h0000_1234, 0, 16'h000F, 4, 32'h0000_00A0);
        chk("t2_req_addr", req_addr_first, 32'h0000_1230);
        chk("t2_req_cyc", req_cyc, 1);
        chk("t2_miss_cyc", miss_cyc, 7);
        chk("t2_rep_cnt", rep_cnt, 1);
        check_writes(4, 32'h0000_00A0);

        // 3: request backpressure
        clear_logs();
        run_miss(32'h0000_1234, 3, 16'h000F, 4, 32'h0000_00B0);
        chk("t3_req_cyc", req_cyc, 4);
        chk("t3_req_addr", req_addr_first, 32'h0000_1230);
        chk("t3_addr_moved", req_addr_moved, 1'b0);
        chk("t3_miss_cyc", miss_cyc, 10);
        check_writes(4, 32'h0000_00B0);

        // 4: gapped beats 1,0,1,0,0,1,1
        clear_logs();
        run_miss(32'h0000_4AFC, 0, 16'h0065, 7, 32'h0000_00C0);
        chk("t4_req_addr", req_addr_first, 32'h0000_4AF0);
        chk("t4_miss_cyc", miss_cyc, 10);
        chk("t4_rep_cnt", rep_cnt, 1);
        check_writes(4, 32'h0000_00C0);

        // 5: 20 hitting cycles
        clear_logs();
        lookup_hit_i = 1'b1; pc_f_i = 32'h0000_8000;
        repeat (20) tick();
        chk("t5_req_cyc", req_cyc, 0);
        chk("t5_miss_cyc", miss_cyc, 0);
        chk("t5_writes", wr_idx_q.size(), 0);

        // 6: reset in the middle of a fill, then a clean restart
        clear_logs();
        pc_f_i = 32'h0000_2008; lookup_hit_i = 1'b0;
        tick();
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0000_00E0 + 32'(i);
            tick();
        end
        mem_rsp_valid_i = 1'b0;
        chk("t6_pre_writes", wr_idx_q.size(), 2);
        #2 rst_n_i = 1'b0;
        #1;
        chk("t6_rst_miss", instr_miss_f_o, 1'b0);
        chk("t6_rst_req", mem_req_valid_o, 1'b0);
        chk("t6_rst_we", fill_we_o, 1'b0);
        chk("t6_rst_rep", instr_cache_rep_en_o, 1'b0);
        chk("t6_rst_fill_addr", fill_addr_o, 32'h0);
        tick();
        lookup_hit_i = 1'b1;
        rst_n_i = 1'b1;
        tick();
        clear_logs();
        run_miss(32'h0000_2008, 0, 16'h000F, 4, 32'h0000_00D0);
        chk("t6_req_addr", req_addr_first, 32'h0000_2000);
        chk("t6_rep_cnt", rep_cnt, 1);
        check_writes(4, 32'h0000_00D0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
